// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote mid-bit sampling, false-start rejection, framing/parity/overrun
// detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          RST,
   input  logic                          rx_input_data,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [2:0]                    rx_state,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CW   = $clog2(CLK_DIV);
   localparam int unsigned H    = CLK_DIV / 2;
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned NW   = AW + 1;

   localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SAMP_A   = CW'(H - 1);
   localparam logic [CW-1:0] SAMP_B   = CW'(H);
   localparam logic [CW-1:0] DECIDE   = CW'(H + 1);
   localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STP = 4'(STOP_BITS - 1);
   localparam logic          ODD_MODE = (PARITY == 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PAR    = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic                 meta_q, s_q, s_prev_q;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic                 stop_bad_q, stop_bad_d;
   logic                 samp_a_q, samp_b_q;
   logic                 frame_err_q, parity_err_q, overrun_q;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wptr_q, rptr_q;
   logic [NW-1:0]        count_q, count_d;
   logic [DATA_BITS-1:0] last_q;

   logic decide, maj, last_stop, stop_fail, push_try, push, pop, full, drop;

   assign decide    = (state_q != IDLE) && (cnt_q == DECIDE);
   assign maj       = (samp_a_q & samp_b_q) | (samp_a_q & s_q) | (samp_b_q & s_q);
   assign last_stop = (state_q == STOP) && decide && (bit_idx_q == LAST_STP);
   assign stop_fail = stop_bad_q | ~maj;
   assign pop       = rx_valid && rx_ready;
   assign full      = (count_q == NW'(FIFO_DEPTH));
   assign push_try  = last_stop && !stop_fail && !par_bad_q;
   assign push      = push_try && (!full || pop);
   assign drop      = push_try && full && !pop;

   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      stop_bad_d = stop_bad_q;
      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            if (!s_q && s_prev_q) begin
               state_d    = START;
               par_bad_d  = 1'b0;
               stop_bad_d = 1'b0;
            end
         end
         START: begin
            if (decide) begin
               state_d   = maj ? IDLE : DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (decide) begin
               shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == LAST_BIT) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         PAR: begin
            if (decide) begin
               // XOR over data and parity bit must equal 1 in odd mode, 0 in even mode
               par_bad_d = (^shift_q) ^ maj ^ ODD_MODE;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (decide) begin
               if (!maj) stop_bad_d = 1'b1;
               if (bit_idx_q == LAST_STP) state_d = IDLE;
               else bit_idx_d = bit_idx_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + NW'(1);
         2'b01:   count_d = count_q - NW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         meta_q       <= 1'b1;
         s_q          <= 1'b1;
         s_prev_q     <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_bad_q    <= 1'b0;
         stop_bad_q   <= 1'b0;
         samp_a_q     <= 1'b1;
         samp_b_q     <= 1'b1;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         last_q       <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         meta_q       <= rx_input_data;
         s_q          <= meta_q;
         s_prev_q     <= s_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_bad_q    <= par_bad_d;
         stop_bad_q   <= stop_bad_d;
         if (cnt_q == SAMP_A) samp_a_q <= s_q;
         if (cnt_q == SAMP_B) samp_b_q <= s_q;
         // Frame error outranks parity error
         frame_err_q  <= last_stop && stop_fail;
         parity_err_q <= last_stop && !stop_fail && par_bad_q;
         overrun_q    <= drop;
         if (push) begin
            mem_q[wptr_q] <= shift_q;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (pop) begin
            last_q <= mem_q[rptr_q];
            rptr_q <= rptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   // Empty FIFO keeps showing the most recently popped byte
   assign rx_data    = rx_valid ? mem_q[rptr_q] : last_q;
   assign rx_valid   = (count_q != '0);
   assign fifo_count = count_q;
   assign rx_state   = state_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance driven with directed and random frames.
module tb_uart_rx_fifo;

   localparam int unsigned CLK_DIV = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a_line, a_ready, b_line, b_ready;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid;
   logic [2:0] a_state, b_state;
   logic       a_ferr, a_perr, a_ovr, b_ferr, b_perr, b_ovr;
   logic [2:0] a_count, b_count;

   uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
   dut_a (
      .clk(clk), .RST(rst), .rx_input_data(a_line), .rx_data(a_data), .rx_valid(a_valid),
      .rx_ready(a_ready), .rx_state(a_state), .frame_err(a_ferr), .parity_err(a_perr),
      .overrun(a_ovr), .fifo_count(a_count)
   );

   uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
   dut_b (
      .clk(clk), .RST(rst), .rx_input_data(b_line), .rx_data(b_data), .rx_valid(b_valid),
      .rx_ready(b_ready), .rx_state(b_state), .frame_err(b_ferr), .parity_err(b_perr),
      .overrun(b_ovr), .fifo_count(b_count)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Observation log: popped bytes and cycle counts of each output being high
   logic [7:0] a_pops[$];
   logic [7:0] b_pops[$];
   int a_vcyc = 0, a_fcyc = 0, a_pcyc = 0, a_ocyc = 0, a_scyc = 0;
   int b_vcyc = 0, b_fcyc = 0, b_pcyc = 0, b_ocyc = 0;

   always @(negedge clk) begin
      if (a_valid && a_ready) a_pops.push_back(a_data);
      if (b_valid && b_ready) b_pops.push_back(b_data);
      if (a_valid) a_vcyc++;
      if (a_ferr) a_fcyc++;
      if (a_perr) a_pcyc++;
      if (a_ovr) a_ocyc++;
      if (a_state == 3'd1) a_scyc++;
      if (b_valid) b_vcyc++;
      if (b_ferr) b_fcyc++;
      if (b_perr) b_pcyc++;
      if (b_ovr) b_ocyc++;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input bit to_b, input logic v);
      if (to_b) b_line = v;
      else a_line = v;
      idle(CLK_DIV);
   endtask

   task automatic send_frame(input bit to_b, input logic [7:0] d, input bit with_par,
                             input logic par, input logic stop);
      drive_bit(to_b, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(to_b, d[i]);
      if (with_par) drive_bit(to_b, par);
      drive_bit(to_b, stop);
      if (to_b) b_line = 1'b1;
      else a_line = 1'b1;
      idle(2);
   endtask

   task automatic test_reset;
      rst = 1'b1; a_line = 1'b1; b_line = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (a_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", a_state); end
      n_cmp++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b/%b want 0/0", a_valid, b_valid);
      end
      n_cmp++;
      if (a_count !== 3'd0 || b_count !== 3'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d/%0d want 0/0", a_count, b_count);
      end
      n_cmp++;
      if (a_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", a_data); end
      n_cmp++;
      if ({a_ferr, a_perr, a_ovr, b_ferr, b_perr, b_ovr} !== 6'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000000",
                            {a_ferr, a_perr, a_ovr, b_ferr, b_perr, b_ovr});
      end
      idle(1);
   endtask

   task automatic test_8n1;
      int base = a_pops.size();
      int v0 = a_vcyc, f0 = a_fcyc, p0 = a_pcyc, o0 = a_ocyc;
      a_ready = 1'b1;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      idle(20);
      n_cmp++;
      if (a_pops.size() != base + 1) begin
         n_fail++; $display("FAIL 8n1_pop_count: got %0d want 1", a_pops.size() - base);
      end else begin
         n_cmp++;
         if (a_pops[base] !== 8'hA5) begin
            n_fail++; $display("FAIL 8n1_data: got %h want a5", a_pops[base]);
         end
      end
      n_cmp++;
      if (a_vcyc - v0 != 1) begin
         n_fail++; $display("FAIL 8n1_valid_cycles: got %0d want 1", a_vcyc - v0);
      end
      n_cmp++;
      if ((a_fcyc - f0) + (a_pcyc - p0) + (a_ocyc - o0) != 0) begin
         n_fail++; $display("FAIL 8n1_flags: got %0d flag cycles want 0",
                            (a_fcyc - f0) + (a_pcyc - p0) + (a_ocyc - o0));
      end
   endtask

   task automatic test_false_start;
      int base = a_pops.size();
      int s0 = a_scyc, f0 = a_fcyc;
      a_line = 1'b0;
      idle(4);
      a_line = 1'b1;
      idle(40);
      n_cmp++;
      if (a_scyc - s0 == 0) begin
         n_fail++; $display("FAIL false_start_seen: got 0 START cycles want >0");
      end
      n_cmp++;
      if (a_state !== 3'd0) begin
         n_fail++; $display("FAIL false_start_state: got %0d want 0", a_state);
      end
      n_cmp++;
      if (a_pops.size() != base || a_fcyc != f0 || a_count !== 3'd0) begin
         n_fail++; $display("FAIL false_start_effect: got pops=%0d ferr=%0d count=%0d want 0/0/0",
                            a_pops.size() - base, a_fcyc - f0, a_count);
      end
   endtask

   task automatic test_frame_err;
      int base = a_pops.size();
      int f0 = a_fcyc, p0 = a_pcyc;
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      idle(20);
      n_cmp++;
      if (a_fcyc - f0 != 1) begin
         n_fail++; $display("FAIL frame_err_pulse: got %0d cycles want 1", a_fcyc - f0);
      end
      n_cmp++;
      if (a_count !== 3'd0 || a_pops.size() != base || a_pcyc != p0) begin
         n_fail++; $display("FAIL frame_err_discard: got count=%0d pops=%0d perr=%0d want 0/0/0",
                            a_count, a_pops.size() - base, a_pcyc - p0);
      end
   endtask

   task automatic test_parity;
      int base = b_pops.size();
      int p0 = b_pcyc, f0 = b_fcyc;
      b_ready = 1'b1;
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      idle(20);
      n_cmp++;
      if (b_pcyc - p0 != 1 || b_pops.size() != base) begin
         n_fail++; $display("FAIL parity_bad: got perr=%0d pops=%0d want 1/0",
                            b_pcyc - p0, b_pops.size() - base);
      end
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      idle(20);
      n_cmp++;
      if (b_pops.size() != base + 1) begin
         n_fail++; $display("FAIL parity_good_count: got %0d want 1", b_pops.size() - base);
      end else begin
         n_cmp++;
         if (b_pops[base] !== 8'h07) begin
            n_fail++; $display("FAIL parity_good_data: got %h want 07", b_pops[base]);
         end
      end
      n_cmp++;
      if (b_pcyc - p0 != 1 || b_fcyc != f0) begin
         n_fail++; $display("FAIL parity_good_flags: got perr=%0d ferr=%0d want 1/0",
                            b_pcyc - p0, b_fcyc - f0);
      end
   endtask

   task automatic test_overrun;
      int base = a_pops.size();
      int o0 = a_ocyc;
      a_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send_frame(1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
      idle(4);
      n_cmp++;
      if (a_count !== 3'd4 || a_ocyc != o0) begin
         n_fail++; $display("FAIL overrun_fill: got count=%0d ovr=%0d want 4/0", a_count, a_ocyc - o0);
      end
      send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
      idle(4);
      n_cmp++;
      if (a_ocyc - o0 != 1 || a_count !== 3'd4) begin
         n_fail++; $display("FAIL overrun_pulse: got ovr=%0d count=%0d want 1/4", a_ocyc - o0, a_count);
      end
      a_ready = 1'b1;
      idle(10);
      n_cmp++;
      if (a_pops.size() != base + 4) begin
         n_fail++; $display("FAIL overrun_drain_count: got %0d want 4", a_pops.size() - base);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (a_pops[base + k] !== 8'(k + 1)) begin
               n_fail++; $display("FAIL overrun_order[%0d]: got %h want %h", k, a_pops[base + k], k + 1);
            end
         end
      end
      n_cmp++;
      if (a_count !== 3'd0 || a_valid !== 1'b0 || a_data !== 8'h04) begin
         n_fail++; $display("FAIL overrun_empty: got count=%0d valid=%b data=%h want 0/0/04",
                            a_count, a_valid, a_data);
      end
   endtask

   // Random 8E1 frames; model: FIFO of 4, a ready frame drains everything, full+not ready drops
   task automatic test_random;
      logic [7:0] exp_q[$];
      logic [7:0] exp_pops[$];
      int base = b_pops.size();
      int f0 = b_fcyc, p0 = b_pcyc, o0 = b_ocyc;
      int ef = 0, ep = 0, eo = 0;
      for (int n = 0; n < 24; n++) begin
         logic [7:0] d = 8'($urandom);
         int kind = $urandom_range(0, 9);
         bit rdy = ($urandom_range(0, 3) == 0);
         logic par = ^d;
         logic stop = 1'b1;
         if (kind == 0) begin stop = 1'b0; par = 1'($urandom); end
         else if (kind == 1) par = ~par;
         b_ready = rdy;
         if (rdy) while (exp_q.size() > 0) exp_pops.push_back(exp_q.pop_front());
         if (kind == 0) ef++;
         else if (kind == 1) ep++;
         else if (rdy) exp_pops.push_back(d);
         else if (exp_q.size() == 4) eo++;
         else exp_q.push_back(d);
         send_frame(1'b1, d, 1'b1, par, stop);
         idle($urandom_range(0, 8));
      end
      b_ready = 1'b1;
      idle(20);
      while (exp_q.size() > 0) exp_pops.push_back(exp_q.pop_front());
      n_cmp++;
      if (b_pops.size() - base != exp_pops.size()) begin
         n_fail++; $display("FAIL random_pop_count: got %0d want %0d", b_pops.size() - base,
                            exp_pops.size());
      end else begin
         for (int k = 0; k < exp_pops.size(); k++) begin
            n_cmp++;
            if (b_pops[base + k] !== exp_pops[k]) begin
               n_fail++; $display("FAIL random_data[%0d]: got %h want %h", k, b_pops[base + k],
                                  exp_pops[k]);
            end
         end
      end
      n_cmp++;
      if (b_fcyc - f0 != ef || b_pcyc - p0 != ep || b_ocyc - o0 != eo) begin
         n_fail++; $display("FAIL random_flags: got ferr=%0d perr=%0d ovr=%0d want %0d/%0d/%0d",
                            b_fcyc - f0, b_pcyc - p0, b_ocyc - o0, ef, ep, eo);
      end
      n_cmp++;
      if (b_count !== 3'd0) begin
         n_fail++; $display("FAIL random_final_count: got %0d want 0", b_count);
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_false_start();
      test_frame_err();
      test_parity();
      test_overrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
